// File: rtl/demux_pkg.sv
// demux_pkg: shared lane identifiers for the 1-to-4 buffered demultiplexer.
package demux_pkg;
  localparam int NUM_LANES = 4;
  typedef enum logic [1:0] {LANE_A = 2'b00, LANE_B = 2'b01, LANE_C = 2'b10, LANE_D = 2'b11} lane_t;
endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: per-lane circular FIFO; storage is never reset, only pointers and count.
module lane_fifo #(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [aw:0] cnt_q, cnt_d;
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (!push && pop) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
  assign head_data = mem_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (aw+1)'(depth));
  no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/demux4_buffered.sv
// demux4_buffered: steers one valid/ready stream into four independently buffered lanes.
module demux4_buffered
  import demux_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [width-1:0]     in_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [width-1:0]     out_a_data,
  output logic [width-1:0]     out_b_data,
  output logic [width-1:0]     out_c_data,
  output logic [width-1:0]     out_d_data,
  output logic                 idle
);
  lane_t sel;
  logic [NUM_LANES-1:0] push, empty, full;
  logic [width-1:0] head [NUM_LANES];
  // Undefined select bits fall through to lane a.
  always_comb begin
    case (in_sel)
      2'b01:   sel = LANE_B;
      2'b10:   sel = LANE_C;
      2'b11:   sel = LANE_D;
      default: sel = LANE_A;
    endcase
  end
  assign in_ready = ~full[sel];
  assign push     = (in_valid && in_ready) ? {{(NUM_LANES-1){1'b0}}, 1'b1} << sel : '0;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(.width(width), .depth(depth)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (out_valid[i] & out_ready[i]),
      .head_data (head[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end
  assign out_valid  = ~empty;
  assign out_a_data = head[0];
  assign out_b_data = head[1];
  assign out_c_data = head[2];
  assign out_d_data = head[3];
  assign idle       = &empty;
endmodule

// File: tb/tb_demux4_buffered.sv
// tb_demux4_buffered: queue-per-lane reference model with directed and random traffic.
module tb_demux4_buffered;
  localparam int W = 16;
  localparam int D = 2;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, idle;
  logic [1:0] in_sel = 2'b00;
  logic [W-1:0] in_data = '0;
  logic [3:0] out_valid, out_ready = 4'b0000;
  logic [W-1:0] oa, ob, oc, odd;
  logic [W-1:0] od [4];
  logic [W-1:0] q [4][$];
  int checks = 0, errors = 0;

  demux4_buffered #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_a_data(oa), .out_b_data(ob), .out_c_data(oc), .out_d_data(odd), .idle(idle)
  );
  assign od[0] = oa;
  assign od[1] = ob;
  assign od[2] = oc;
  assign od[3] = odd;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Monitor/scoreboard: expected state is the queue contents, sampled on the falling edge.
  always @(negedge clk) begin
    logic acc;
    logic [3:0] ev;
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
      chk("reset_idle", {31'd0, idle}, 32'd1);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      for (int i = 0; i < 4; i++) ev[i] = q[i].size() != 0;
      chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
      chk("idle", {31'd0, idle}, {31'd0, ev == 4'b0000});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q[in_sel].size() < D});
      acc = in_valid && q[in_sel].size() < D;
      for (int i = 0; i < 4; i++)
        if (ev[i] && out_ready[i]) chk($sformatf("lane%0d_data", i), {16'd0, od[i]}, {16'd0, q[i].pop_front()});
      if (acc) q[in_sel].push_back(in_data);
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic push_retry(input logic [1:0] s, input logic [W-1:0] d, inout logic [3:0] r);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      in_valid = 1'b1; in_sel = s; in_data = d; out_ready = r;
      #1 acc = in_ready;
      @(posedge clk); #1;
      r[s] = ~r[s];
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: lane %0d word %h never accepted", s, d);
    end
  endtask

  initial begin
    logic [3:0] r;
    for (int s = 0; s < 4; s++) step(1'b0, 2'(s), '0, 4'b0000);
    rst = 1'b0;
    // Route one word per lane.
    step(1, 2'b00, 16'h1111, 4'b1111);
    step(1, 2'b01, 16'h2222, 4'b1111);
    step(1, 2'b10, 16'h3333, 4'b1111);
    step(1, 2'b11, 16'h4444, 4'b1111);
    step(0, 2'b00, '0, 4'b1111);
    // Lane c stalls; lane a still flows.
    step(1, 2'b10, 16'h00A0, 4'b1011);
    step(1, 2'b10, 16'h00A1, 4'b1011);
    step(1, 2'b10, 16'h00A2, 4'b1011);
    step(1, 2'b00, 16'h0055, 4'b1011);
    step(1, 2'b00, 16'h0056, 4'b1011);
    step(0, 2'b00, '0, 4'b1111);
    step(0, 2'b00, '0, 4'b1111);
    // Lane b ordering across pointer wrap with toggling consumer.
    r = 4'b0010;
    for (int k = 1; k <= 6; k++) push_retry(2'b01, W'(k), r);
    for (int k = 0; k < 4; k++) step(0, 2'b01, '0, 4'b1111);
    // Full lane d with a same-cycle pop: push must be refused.
    step(1, 2'b11, 16'hD000, 4'b0000);
    step(1, 2'b11, 16'hD001, 4'b0000);
    step(1, 2'b11, 16'hD002, 4'b1000);
    step(1, 2'b11, 16'hD003, 4'b0000);
    step(0, 2'b11, '0, 4'b1111);
    step(0, 2'b11, '0, 4'b1111);
    step(0, 2'b11, '0, 4'b1111);
    // Asynchronous reset with lanes a and c occupied.
    step(1, 2'b00, 16'hAAAA, 4'b0000);
    step(1, 2'b10, 16'hCCCC, 4'b0000);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'd0);
    chk("async_rst_idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    step(1, 2'b10, 16'hC0DE, 4'b0000);
    step(1, 2'b00, 16'hBEEF, 4'b1111);
    step(0, 2'b00, '0, 4'b1111);
    // Random traffic.
    for (int n = 0; n < 2000; n++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), 4'($urandom));
    for (int n = 0; n < 6; n++) step(0, 2'b00, '0, 4'b1111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
